// File: rtl/combination_lock_param_if.sv
// Bus between the button/encoder front end and the combination lock: dial and button
// pulses, relock and code programming inputs, plus the lock's registered status outputs.
interface combination_lock_param_if #(
   parameter int unsigned COUNT_W    = 5,
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned MAX_FAILS  = 3
);
   localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
   localparam int unsigned FailW = $clog2(MAX_FAILS + 1);

   logic               Right;
   logic               Left;
   logic               Center;
   logic [COUNT_W-1:0] Count;
   logic               Relock;
   logic               ProgWe;
   logic [IdxW-1:0]    ProgIdx;
   logic [COUNT_W-1:0] ProgVal;

   logic [1:0]         state;
   logic               Locked;
   logic               LockedOut;
   logic [IdxW-1:0]    DigitIdx;
   logic [FailW-1:0]   FailCnt;

   modport master (
      output Right, Left, Center, Count, Relock, ProgWe, ProgIdx, ProgVal,
      input  state, Locked, LockedOut, DigitIdx, FailCnt
   );

   modport slave (
      input  Right, Left, Center, Count, Relock, ProgWe, ProgIdx, ProgVal,
      output state, Locked, LockedOut, DigitIdx, FailCnt
   );
endinterface

// File: rtl/combination_lock_param.sv
// Reprogrammable NUM_DIGITS-digit combination lock with consecutive-failure lockout
// and optional automatic relock after AUTO_RELOCK cycles open.
module combination_lock_param #(
   parameter int unsigned                   COUNT_W        = 5,
   parameter int unsigned                   NUM_DIGITS     = 3,
   parameter logic [NUM_DIGITS*COUNT_W-1:0] CODE_INIT      = {5'd17, 5'd7, 5'd13},
   parameter int unsigned                   MAX_FAILS      = 3,
   parameter int unsigned                   LOCKOUT_CYCLES = 1024,
   parameter int unsigned                   AUTO_RELOCK    = 0
) (
   input logic                     Clk,
   input logic                     reset,
   combination_lock_param_if.slave bus
);
   localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
   localparam int unsigned FailW  = $clog2(MAX_FAILS + 1);
   localparam int unsigned TmrMax = (LOCKOUT_CYCLES > AUTO_RELOCK) ? LOCKOUT_CYCLES
                                                                   : AUTO_RELOCK;
   localparam int unsigned TmrW   = $clog2(TmrMax + 1);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StEntry   = 2'd1,
      StOpen    = 2'd2,
      StLockout = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IdxW-1:0]    digit_idx_q, digit_idx_d;
   logic [FailW-1:0]   fail_cnt_q, fail_cnt_d;
   logic [TmrW-1:0]    timer_q, timer_d;
   logic [COUNT_W-1:0] code_q [NUM_DIGITS];
   logic [COUNT_W-1:0] code_d [NUM_DIGITS];
   logic [COUNT_W-1:0] code_init [NUM_DIGITS];
   logic               locked_q, locked_d;
   logic               locked_out_q, locked_out_d;

   logic               any_evt;
   logic               clean_evt;
   logic               last_digit;
   logic               exp_btn;
   logic [COUNT_W-1:0] cur_digit;
   logic               digit_ok;

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         code_init[i] = CODE_INIT[i*COUNT_W +: COUNT_W];
      end
   end

   // Decode the button expected for the current digit and whether this cycle matches it.
   always_comb begin
      any_evt    = bus.Right | bus.Left | bus.Center;
      clean_evt  = $onehot({bus.Right, bus.Left, bus.Center});
      last_digit = (digit_idx_q == IdxW'(NUM_DIGITS - 1));
      cur_digit  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx_q == IdxW'(i)) begin
            cur_digit = code_q[i];
         end
      end
      if (last_digit) begin
         exp_btn = bus.Center;
      end else if (digit_idx_q[0]) begin
         exp_btn = bus.Right;
      end else begin
         exp_btn = bus.Left;
      end
      digit_ok = clean_evt && exp_btn && (bus.Count == cur_digit);
   end

   always_comb begin
      state_d     = state_q;
      digit_idx_d = digit_idx_q;
      fail_cnt_d  = fail_cnt_q;
      timer_d     = timer_q;
      code_d      = code_q;

      unique case (state_q)
         StIdle: begin
            if (clean_evt && bus.Right) begin
               state_d     = StEntry;
               digit_idx_d = '0;
            end
         end

         StEntry: begin
            if (digit_ok) begin
               if (last_digit) begin
                  state_d     = StOpen;
                  fail_cnt_d  = '0;
                  digit_idx_d = '0;
                  timer_d     = '0;
               end else begin
                  digit_idx_d = digit_idx_q + IdxW'(1);
               end
            end else if (any_evt) begin
               digit_idx_d = '0;
               if (fail_cnt_q == FailW'(MAX_FAILS - 1)) begin
                  state_d    = StLockout;
                  fail_cnt_d = FailW'(MAX_FAILS);
                  timer_d    = '0;
               end else begin
                  state_d    = StIdle;
                  fail_cnt_d = fail_cnt_q + FailW'(1);
               end
            end
         end

         StOpen: begin
            // Out-of-range indices match no digit and are dropped.
            if (bus.ProgWe) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (bus.ProgIdx == IdxW'(i)) begin
                     code_d[i] = bus.ProgVal;
                  end
               end
            end
            if (bus.Relock) begin
               state_d = StIdle;
            end else if (AUTO_RELOCK != 0) begin
               if (timer_q == TmrW'(AUTO_RELOCK - 1)) begin
                  state_d = StIdle;
               end else begin
                  timer_d = timer_q + TmrW'(1);
               end
            end
         end

         StLockout: begin
            if (timer_q == TmrW'(LOCKOUT_CYCLES - 1)) begin
               state_d    = StIdle;
               fail_cnt_d = '0;
            end else begin
               timer_d = timer_q + TmrW'(1);
            end
         end
      endcase

      locked_d     = (state_d != StOpen);
      locked_out_d = (state_d == StLockout);
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q      <= StIdle;
         digit_idx_q  <= '0;
         fail_cnt_q   <= '0;
         timer_q      <= '0;
         code_q       <= code_init;
         locked_q     <= 1'b1;
         locked_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_idx_q  <= digit_idx_d;
         fail_cnt_q   <= fail_cnt_d;
         timer_q      <= timer_d;
         code_q       <= code_d;
         locked_q     <= locked_d;
         locked_out_q <= locked_out_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.Locked    = locked_q;
   assign bus.LockedOut = locked_out_q;
   assign bus.DigitIdx  = digit_idx_q;
   assign bus.FailCnt   = fail_cnt_q;
endmodule

// File: tb/tb_combination_lock_param.sv
// Bench for combination_lock_param: directed scenarios plus randomized traffic checked
// against a behavioural model of the lock rules.
module tb_combination_lock_param;
   localparam int ND = 3;
   localparam int MF = 3;
   localparam int LC = 16;

   logic Clk = 1'b0;
   logic rst1, rst2;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 Clk = ~Clk;

   combination_lock_param_if #(.COUNT_W(5), .NUM_DIGITS(ND), .MAX_FAILS(MF)) bus1 ();
   combination_lock_param_if #(.COUNT_W(5), .NUM_DIGITS(ND), .MAX_FAILS(MF)) bus2 ();

   combination_lock_param #(
      .COUNT_W(5), .NUM_DIGITS(ND), .CODE_INIT({5'd17, 5'd7, 5'd13}), .MAX_FAILS(MF),
      .LOCKOUT_CYCLES(LC), .AUTO_RELOCK(0)
   ) dut1 (.Clk(Clk), .reset(rst1), .bus(bus1));

   combination_lock_param #(
      .COUNT_W(5), .NUM_DIGITS(ND), .CODE_INIT({5'd17, 5'd7, 5'd13}), .MAX_FAILS(MF),
      .LOCKOUT_CYCLES(LC), .AUTO_RELOCK(8)
   ) dut2 (.Clk(Clk), .reset(rst2), .bus(bus2));

   logic [7:0] obs1, obs2;
   assign obs1 = {bus1.state, bus1.Locked, bus1.LockedOut, bus1.DigitIdx, bus1.FailCnt};
   assign obs2 = {bus2.state, bus2.Locked, bus2.LockedOut, bus2.DigitIdx, bus2.FailCnt};

   // Packed expectation: state, Locked, LockedOut, DigitIdx, FailCnt.
   function automatic logic [7:0] ev(input int st, input int idx, input int f);
      return {2'(st), (st == 2) ? 1'b0 : 1'b1, (st == 3) ? 1'b1 : 1'b0, 2'(idx), 2'(f)};
   endfunction

   // Reference model of dut1: state 0 idle, 1 entering, 2 open, 3 locked out.
   int m_state, m_idx, m_fails, m_timer;
   int m_code [ND];

   task automatic model_reset();
      m_state = 0; m_idx = 0; m_fails = 0; m_timer = 0;
      m_code[0] = 13; m_code[1] = 7; m_code[2] = 17;
   endtask

   task automatic model_step(input bit r, l, c, input int cnt, input bit rl, we,
                             input int pi, pv);
      int  n;
      bit  want;
      n = int'(r) + int'(l) + int'(c);
      case (m_state)
         0: if (n == 1 && r) begin m_state = 1; m_idx = 0; end
         1: if (n > 0) begin
            if (m_idx == ND - 1) want = c;
            else if (m_idx % 2 == 0) want = l;
            else want = r;
            if (n == 1 && want && cnt == m_code[m_idx]) begin
               if (m_idx == ND - 1) begin m_state = 2; m_idx = 0; m_fails = 0; end
               else m_idx++;
            end else begin
               m_idx = 0;
               if (m_fails + 1 < MF) begin m_fails++; m_state = 0; end
               else begin m_fails = MF; m_state = 3; m_timer = 0; end
            end
         end
         2: begin
            if (we && pi < ND) m_code[pi] = pv;
            if (rl) m_state = 0;
         end
         default: begin
            m_timer++;
            if (m_timer == LC) begin m_state = 0; m_fails = 0; end
         end
      endcase
   endtask

   task automatic clear1();
      bus1.Right = 0; bus1.Left = 0; bus1.Center = 0; bus1.Relock = 0; bus1.ProgWe = 0;
   endtask

   task automatic step1(input bit r, l, c, input int cnt, input bit rl, we, input int pi, pv);
      bus1.Right = r; bus1.Left = l; bus1.Center = c; bus1.Count = 5'(cnt);
      bus1.Relock = rl; bus1.ProgWe = we; bus1.ProgIdx = 2'(pi); bus1.ProgVal = 5'(pv);
      @(posedge Clk);
      model_step(r, l, c, cnt, rl, we, pi, pv);
      #1;
      clear1();
   endtask

   task automatic press1(input bit r, l, c, input int cnt);
      step1(r, l, c, cnt, 0, 0, 0, 0);
   endtask

   task automatic step2(input bit r, l, c, input int cnt);
      bus2.Right = r; bus2.Left = l; bus2.Center = c; bus2.Count = 5'(cnt);
      @(posedge Clk);
      #1;
      bus2.Right = 0; bus2.Left = 0; bus2.Center = 0;
   endtask

   task automatic open1();
      press1(1, 0, 0, 0);
      press1(0, 1, 0, m_code[0]);
      press1(1, 0, 0, m_code[1]);
      press1(0, 0, 1, m_code[2]);
   endtask

   task automatic test_reset();
      clear1();
      bus1.Count = '0; bus1.ProgIdx = '0; bus1.ProgVal = '0;
      bus2.Right = 0; bus2.Left = 0; bus2.Center = 0; bus2.Count = '0;
      bus2.Relock = 0; bus2.ProgWe = 0; bus2.ProgIdx = '0; bus2.ProgVal = '0;
      bus1.Right = 1; bus2.Right = 1;
      rst1 = 1; rst2 = 1;
      @(posedge Clk);
      model_reset();
      #1;
      rst1 = 0; rst2 = 0; bus1.Right = 0; bus2.Right = 0;
      vectors++;
      if (obs1 !== ev(0, 0, 0)) begin
         miscompares++; $display("FAIL reset1 got %h want %h", obs1, ev(0, 0, 0));
      end
      vectors++;
      if (obs2 !== ev(0, 0, 0)) begin
         miscompares++; $display("FAIL reset2 got %h want %h", obs2, ev(0, 0, 0));
      end
   endtask

   task automatic test_open();
      int cnt [4] = '{0, 13, 7, 17};
      int est [4] = '{1, 1, 1, 2};
      int eidx [4] = '{0, 1, 2, 0};
      for (int k = 0; k < 4; k++) begin
         press1(k == 0 || k == 2, k == 1, k == 3, cnt[k]);
         vectors++;
         if (obs1 !== ev(est[k], eidx[k], 0)) begin
            miscompares++;
            $display("FAIL open_step%0d got %h want %h", k, obs1, ev(est[k], eidx[k], 0));
         end
      end
      step1(0, 0, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (obs1 !== ev(0, 0, 0)) begin
         miscompares++; $display("FAIL open_relock got %h want %h", obs1, ev(0, 0, 0));
      end
   endtask

   task automatic test_lockout();
      int st, f;
      for (int n = 1; n <= 3; n++) begin
         press1(1, 0, 0, 0);
         press1(0, 1, 0, 12);
         st = (n == 3) ? 3 : 0;
         vectors++;
         if (obs1 !== ev(st, 0, n)) begin
            miscompares++; $display("FAIL fail%0d got %h want %h", n, obs1, ev(st, 0, n));
         end
      end
      for (int k = 1; k <= LC; k++) begin
         case (k)
            1: press1(1, 0, 0, 0);
            2: press1(0, 1, 0, 13);
            3: press1(1, 0, 0, 7);
            4: press1(0, 0, 1, 17);
            default: press1(0, 0, 0, 0);
         endcase
         st = (k < LC) ? 3 : 0;
         f  = (k < LC) ? 3 : 0;
         vectors++;
         if (obs1 !== ev(st, 0, f)) begin
            miscompares++; $display("FAIL lockout_k%0d got %h want %h", k, obs1, ev(st, 0, f));
         end
      end
   endtask

   task automatic test_program();
      open1();
      step1(0, 0, 0, 0, 0, 1, 1, 9);
      vectors++;
      if (obs1 !== ev(2, 0, 0)) begin
         miscompares++; $display("FAIL prog_write got %h want %h", obs1, ev(2, 0, 0));
      end
      step1(0, 0, 0, 0, 1, 0, 0, 0);
      press1(1, 0, 0, 0); press1(0, 1, 0, 13); press1(1, 0, 0, 7);
      vectors++;
      if (obs1 !== ev(0, 0, 1)) begin
         miscompares++; $display("FAIL prog_oldcode got %h want %h", obs1, ev(0, 0, 1));
      end
      press1(1, 0, 0, 0); press1(0, 1, 0, 13); press1(1, 0, 0, 9); press1(0, 0, 1, 17);
      vectors++;
      if (obs1 !== ev(2, 0, 0)) begin
         miscompares++; $display("FAIL prog_newcode got %h want %h", obs1, ev(2, 0, 0));
      end
      step1(0, 0, 0, 0, 1, 1, 1, 7);
      vectors++;
      if (obs1 !== ev(0, 0, 0)) begin
         miscompares++; $display("FAIL prog_relock got %h want %h", obs1, ev(0, 0, 0));
      end
      press1(1, 0, 0, 0); press1(0, 1, 0, 13); press1(1, 0, 0, 7); press1(0, 0, 1, 17);
      vectors++;
      if (obs1 !== ev(2, 0, 0)) begin
         miscompares++; $display("FAIL prog_restore got %h want %h", obs1, ev(2, 0, 0));
      end
      step1(0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_prog_ignored();
      step1(0, 0, 0, 0, 1, 1, 0, 1);
      vectors++;
      if (obs1 !== ev(0, 0, 0)) begin
         miscompares++; $display("FAIL idle_prog got %h want %h", obs1, ev(0, 0, 0));
      end
      press1(1, 0, 0, 0); press1(0, 1, 0, 13); press1(1, 0, 0, 7); press1(0, 0, 1, 17);
      vectors++;
      if (obs1 !== ev(2, 0, 0)) begin
         miscompares++; $display("FAIL idle_prog_open got %h want %h", obs1, ev(2, 0, 0));
      end
      step1(0, 0, 0, 0, 0, 1, 3, 0);
      step1(0, 0, 0, 0, 1, 0, 0, 0);
      press1(1, 0, 0, 0); press1(0, 1, 0, 13); press1(1, 0, 0, 7); press1(0, 0, 1, 17);
      vectors++;
      if (obs1 !== ev(2, 0, 0)) begin
         miscompares++; $display("FAIL oor_prog_open got %h want %h", obs1, ev(2, 0, 0));
      end
      step1(0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_multi_button();
      press1(1, 0, 0, 0);
      press1(1, 1, 0, 13);
      vectors++;
      if (obs1 !== ev(0, 0, 1)) begin
         miscompares++; $display("FAIL multi_btn got %h want %h", obs1, ev(0, 0, 1));
      end
      open1();
      vectors++;
      if (obs1 !== ev(2, 0, 0)) begin
         miscompares++; $display("FAIL multi_clear got %h want %h", obs1, ev(2, 0, 0));
      end
      step1(0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_auto_relock();
      int st;
      step2(1, 0, 0, 0); step2(0, 1, 0, 13); step2(1, 0, 0, 7); step2(0, 0, 1, 17);
      vectors++;
      if (obs2 !== ev(2, 0, 0)) begin
         miscompares++; $display("FAIL auto_open got %h want %h", obs2, ev(2, 0, 0));
      end
      for (int k = 1; k <= 8; k++) begin
         step2(0, 0, 0, 0);
         st = (k < 8) ? 2 : 0;
         vectors++;
         if (obs2 !== ev(st, 0, 0)) begin
            miscompares++; $display("FAIL auto_k%0d got %h want %h", k, obs2, ev(st, 0, 0));
         end
      end
      step2(1, 0, 0, 0); step2(0, 1, 0, 13);
      vectors++;
      if (obs2 !== ev(1, 1, 0)) begin
         miscompares++; $display("FAIL mid_entry got %h want %h", obs2, ev(1, 1, 0));
      end
      rst2 = 1; bus2.Right = 1; bus2.Count = 5'd7;
      @(posedge Clk);
      #1;
      rst2 = 0; bus2.Right = 0;
      vectors++;
      if (obs2 !== ev(0, 0, 0)) begin
         miscompares++; $display("FAIL mid_reset got %h want %h", obs2, ev(0, 0, 0));
      end
   endtask

   task automatic test_random();
      bit r, l, c, rl, we;
      int cnt, pi, pv, mode;
      logic [2:0] b;
      for (int it = 0; it < 4000; it++) begin
         mode = int'($urandom_range(0, 9));
         b    = 3'($urandom);
         r = 0; l = 0; c = 0; rl = 0; we = 0;
         cnt = int'($urandom_range(0, 31));
         pi  = int'($urandom_range(0, 3));
         pv  = int'($urandom_range(0, 31));
         if ($urandom_range(0, 199) == 0) begin
            bus1.Right = b[2]; bus1.Left = b[1]; bus1.Center = b[0]; bus1.Count = 5'(cnt);
            rst1 = 1;
            @(posedge Clk);
            model_reset();
            #1;
            rst1 = 0;
            clear1();
         end else begin
            case (m_state)
               0: if (mode < 6) r = 1; else {r, l, c} = b;
               1: begin
                  if (mode < 8) begin
                     if (m_idx == ND - 1) c = 1;
                     else if (m_idx % 2 == 0) l = 1;
                     else r = 1;
                     cnt = m_code[m_idx];
                  end else if (mode == 8) begin
                     {r, l, c} = b;
                  end
               end
               2: begin {r, l, c} = b; we = (mode < 4); rl = (mode >= 7); end
               default: {r, l, c} = b;
            endcase
            step1(r, l, c, cnt, rl, we, pi, pv);
         end
         vectors++;
         if (obs1 !== ev(m_state, m_idx, m_fails)) begin
            miscompares++;
            $display("FAIL random_it%0d got %h want %h", it, obs1, ev(m_state, m_idx, m_fails));
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst1 = 0; rst2 = 0;
      test_reset();
      test_open();
      test_lockout();
      test_program();
      test_prog_ignored();
      test_multi_button();
      test_auto_relock();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
